jtcontra_obj_rom_slot: RTL and testbench

SDRAM-side responder for the 007121 object engine's ROM request port. Accepts the engine's level-held `rom_cs`/`rom_addr` requests, issues one SDRAM read per miss through a req/ack/rdy handshake, and returns `rom_ok`/`rom_data` only while the data matches the address currently presented. Sits between the object engine and the SDRAM controller, one instance per 007121.

---
 rtl/jtcontra_pkg.sv | 23 ++
 rtl/jtcontra_rom_tag.sv | 53 +++++
 rtl/jtcontra_obj_rom_slot.sv | 83 ++++++++
 tb/tb_jtcontra_obj_rom_slot.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/jtcontra_pkg.sv
// rtl/jtcontra_pkg.sv - shared types and constants for the 007121 ROM slots
package jtcontra_pkg;

    localparam int SDRAM_AW = 22;
    localparam logic [SDRAM_AW-1:0] OBJ_ROM_OFFSET = 22'h0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } fetch_state_e;

    // Even SDRAM word address: the 32-bit burst always starts on the even word of a pair.
    function automatic logic [SDRAM_AW-1:0] sdram_word_addr(
        input logic [SDRAM_AW-1:0] offset,
        input logic [SDRAM_AW-1:0] rom_word
    );
        logic [SDRAM_AW-1:0] w_sum;
        w_sum = offset + {rom_word[SDRAM_AW-1:1], 1'b0};
        return {w_sum[SDRAM_AW-1:1], 1'b0};
    endfunction

endpackage

// File: rtl/jtcontra_rom_tag.sv
// rtl/jtcontra_rom_tag.sv - single-entry 32-bit ROM data holder with tag compare and half select
// Optional feature macro: JTCONTRA_OBJ_CACHE_EN (compare ignores word bit 0)
module jtcontra_rom_tag
    import jtcontra_pkg::*;
#(
    parameter int AW = 18
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_clr,
    input  logic          i_load,
    input  logic          i_load_valid,
    input  logic [AW-1:0] i_load_tag,
    input  logic [31:0]   i_load_data,
    input  logic          i_cs,
    input  logic [AW-1:0] i_addr,
    output logic          o_hit,
    output logic [15:0]   o_data
);

    logic [31:0]   r_data32;
    logic [AW-1:0] r_tag;
    logic          r_valid;
    logic          w_tag_match;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data32 <= 32'h0;
            r_tag    <= '0;
            r_valid  <= 1'b0;
        end else begin
            if (i_load) begin
                r_data32 <= i_load_data;
                r_tag    <= i_load_tag;
            end
            // A load while clearing still leaves valid low, since i_load_valid tracks the clear.
            if (i_load)
                r_valid <= i_load_valid & ~i_clr;
            else if (i_clr)
                r_valid <= 1'b0;
        end
    end

`ifdef JTCONTRA_OBJ_CACHE_EN
    assign w_tag_match = (i_addr[AW-1:1] == r_tag[AW-1:1]);
`else
    assign w_tag_match = (i_addr == r_tag);
`endif

    assign o_hit  = i_cs & r_valid & w_tag_match;
    assign o_data = i_addr[0] ? r_data32[31:16] : r_data32[15:0];

endmodule

// File: rtl/jtcontra_obj_rom_slot.sv
// rtl/jtcontra_obj_rom_slot.sv - object ROM responder: one SDRAM read per miss, combinational hit
// Optional feature macro: JTCONTRA_OBJ_CACHE_EN (word pair shares one fetch)
module jtcontra_obj_rom_slot
    import jtcontra_pkg::*;
#(
    parameter int                    AW     = 18,
    parameter logic [SDRAM_AW-1:0]   OFFSET = OBJ_ROM_OFFSET
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 downloading,
    input  logic                 rom_cs,
    input  logic [AW-1:0]        rom_addr,
    output logic                 rom_ok,
    output logic [15:0]          rom_data,
    output logic                 sdram_req,
    output logic [SDRAM_AW-1:0]  sdram_addr,
    input  logic                 sdram_ack,
    input  logic                 sdram_rdy,
    input  logic [31:0]          sdram_din
);

    fetch_state_e        r_state;
    fetch_state_e        w_next_state;
    logic [AW-1:0]       r_pend_addr;
    logic                w_hit;
    logic                w_start;
    logic                w_load;
    logic [SDRAM_AW-1:0] w_pend_ext;

    jtcontra_rom_tag #(
        .AW (AW)
    ) u_tag (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_clr        (downloading),
        .i_load       (w_load),
        .i_load_valid (~downloading),
        .i_load_tag   (r_pend_addr),
        .i_load_data  (sdram_din),
        .i_cs         (rom_cs),
        .i_addr       (rom_addr),
        .o_hit        (w_hit),
        .o_data       (rom_data)
    );

    assign w_start = rom_cs & ~w_hit & ~downloading;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= IDLE;
        else
            r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_start)   w_next_state = REQ;
            REQ:     if (sdram_ack) w_next_state = WAIT;
            WAIT:    if (sdram_rdy) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        sdram_req = (r_state == REQ);
        w_load    = (r_state == WAIT) && sdram_rdy;
    end

    // The fetch address is frozen at miss time so a mid-fetch address change cannot mislabel data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_pend_addr <= '0;
        else if ((r_state == IDLE) && w_start)
            r_pend_addr <= rom_addr;
    end

    assign w_pend_ext = SDRAM_AW'(r_pend_addr);
    assign sdram_addr = sdram_word_addr(OFFSET, w_pend_ext);
    assign rom_ok     = w_hit & ~downloading;

endmodule

// File: tb/tb_jtcontra_obj_rom_slot.sv
// tb/tb_jtcontra_obj_rom_slot.sv - directed self-checking bench for jtcontra_obj_rom_slot
module tb_jtcontra_obj_rom_slot;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        downloading;
    logic        rom_cs;
    logic [17:0] rom_addr;
    logic        rom_ok;
    logic [15:0] rom_data;
    logic        sdram_req;
    logic [21:0] sdram_addr;
    logic        sdram_ack;
    logic        sdram_rdy;
    logic [31:0] sdram_din;

    logic        rom_cs2;
    logic [17:0] rom_addr2;
    logic        rom_ok2;
    logic [15:0] rom_data2;
    logic        sdram_req2;
    logic [21:0] sdram_addr2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    jtcontra_obj_rom_slot #(.AW(18), .OFFSET(22'h0)) dut (
        .clk(clk), .rst_n(rst_n), .downloading(downloading),
        .rom_cs(rom_cs), .rom_addr(rom_addr), .rom_ok(rom_ok), .rom_data(rom_data),
        .sdram_req(sdram_req), .sdram_addr(sdram_addr), .sdram_ack(sdram_ack),
        .sdram_rdy(sdram_rdy), .sdram_din(sdram_din)
    );

    jtcontra_obj_rom_slot #(.AW(18), .OFFSET(22'h100000)) dut_off (
        .clk(clk), .rst_n(rst_n), .downloading(1'b0),
        .rom_cs(rom_cs2), .rom_addr(rom_addr2), .rom_ok(rom_ok2), .rom_data(rom_data2),
        .sdram_req(sdram_req2), .sdram_addr(sdram_addr2), .sdram_ack(1'b0),
        .sdram_rdy(1'b0), .sdram_din(32'h0)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; downloading = 1'b0; rom_cs = 1'b0; rom_addr = '0;
        sdram_ack = 1'b0; sdram_rdy = 1'b0; sdram_din = '0;
        rom_cs2 = 1'b1; rom_addr2 = 18'h3FFFF;
        #1;
        check("reset_rom_ok", rom_ok, 0);
        check("reset_rom_data", rom_data, 16'h0);
        check("reset_req", sdram_req, 0);
        check("reset_addr", sdram_addr, 22'h0);
        check("reset_addr_offset", sdram_addr2, 22'h100000);
        step(); step();
        rst_n = 1'b1;

        // offset instance: miss on the top word of the region
        step();
        check("offset_req", sdram_req2, 1);
        check("offset_addr", sdram_addr2, 22'h13FFFE);

        // cold miss: cycle 0 request, ack at 2, rdy at 5, ok at 6
        rom_cs = 1'b1; rom_addr = 18'h00010; #1;
        check("cold_c0_ok", rom_ok, 0);
        step();
        check("cold_c1_req", sdram_req, 1);
        check("cold_c1_addr", sdram_addr, 22'h000010);
        step(); sdram_ack = 1'b1; #1;
        check("cold_c2_req", sdram_req, 1);
        step(); sdram_ack = 1'b0; #1;
        check("cold_c3_req_low", sdram_req, 0);
        step();
        step(); sdram_rdy = 1'b1; sdram_din = 32'hBBBB_AAAA; #1;
        check("cold_c5_ok", rom_ok, 0);
        step(); sdram_rdy = 1'b0; #1;
        check("cold_c6_ok", rom_ok, 1);
        check("cold_c6_data", rom_data, 16'hAAAA);

        // pair neighbour
        rom_addr = 18'h00011; #1;
`ifdef JTCONTRA_OBJ_CACHE_EN
        check("pair_ok_same_cycle", rom_ok, 1);
        check("pair_data", rom_data, 16'hBBBB);
        step();
        check("pair_no_req", sdram_req, 0);
`else
        check("pair_ok_drop", rom_ok, 0);
        step();
        check("pair_refetch_req", sdram_req, 1);
        check("pair_refetch_addr", sdram_addr, 22'h000010);
        sdram_ack = 1'b1;
        step(); sdram_ack = 1'b0; sdram_rdy = 1'b1; sdram_din = 32'hBBBB_AAAA;
        step(); sdram_rdy = 1'b0; #1;
        check("pair_refetch_ok", rom_ok, 1);
        check("pair_refetch_data", rom_data, 16'hBBBB);
`endif

        // address change during WAIT
        rom_addr = 18'h00020;
        step();
        check("mid_req1", sdram_req, 1);
        check("mid_addr1", sdram_addr, 22'h000020);
        sdram_ack = 1'b1;
        step(); sdram_ack = 1'b0; rom_addr = 18'h00040;
        sdram_rdy = 1'b1; sdram_din = 32'h2222_1111;
        step(); sdram_rdy = 1'b0; #1;
        check("mid_ok_after_first", rom_ok, 0);
        step();
        check("mid_req2", sdram_req, 1);
        check("mid_addr2", sdram_addr, 22'h000040);
        sdram_ack = 1'b1;
        step(); sdram_ack = 1'b0; sdram_rdy = 1'b1; sdram_din = 32'h4444_3333; #1;
        check("mid_ok_before_rdy2", rom_ok, 0);
        step(); sdram_rdy = 1'b0; #1;
        check("mid_ok_after_rdy2", rom_ok, 1);
        check("mid_data", rom_data, 16'h3333);

        // downloading pulse during WAIT
        rom_addr = 18'h00080;
        step();
        check("dl_req", sdram_req, 1);
        sdram_ack = 1'b1;
        step(); sdram_ack = 1'b0; downloading = 1'b1;
        sdram_rdy = 1'b1; sdram_din = 32'h8888_7777;
        step(); sdram_rdy = 1'b0; #1;
        check("dl_ok_after_rdy", rom_ok, 0);
        check("dl_idle_blocked", sdram_req, 0);
        step();
        check("dl_still_blocked", sdram_req, 0);
        downloading = 1'b0; #1;
        check("dl_valid_cleared", rom_ok, 0);
        step();
        check("dl_refetch_req", sdram_req, 1);
        check("dl_refetch_addr", sdram_addr, 22'h000080);
        sdram_ack = 1'b1;
        step(); sdram_ack = 1'b0; sdram_rdy = 1'b1; sdram_din = 32'h8888_7777;
        step(); sdram_rdy = 1'b0; #1;
        check("dl_refetch_ok", rom_ok, 1);
        check("dl_refetch_data", rom_data, 16'h7777);

        // async reset in WAIT, then a stray rdy
        rom_addr = 18'h00100;
        step();
        check("rst_req", sdram_req, 1);
        sdram_ack = 1'b1;
        step(); sdram_ack = 1'b0;
        #2 rst_n = 1'b0; rom_cs = 1'b0; #1;
        check("rst_async_ok", rom_ok, 0);
        check("rst_async_req", sdram_req, 0);
        check("rst_async_addr", sdram_addr, 22'h0);
        check("rst_async_data", rom_data, 16'h0);
        step(); rst_n = 1'b1;
        sdram_rdy = 1'b1; sdram_din = 32'hDEAD_BEEF;
        step(); sdram_rdy = 1'b0; rom_cs = 1'b1; rom_addr = 18'h00100; #1;
        check("stray_rdy_ok", rom_ok, 0);
        check("stray_rdy_req", sdram_req, 0);
        step();
        check("post_rst_req", sdram_req, 1);
        check("post_rst_addr", sdram_addr, 22'h000100);
        sdram_ack = 1'b1;
        step(); sdram_ack = 1'b0; sdram_rdy = 1'b1; sdram_din = 32'h1234_5678;
        step(); sdram_rdy = 1'b0; #1;
        check("post_rst_ok", rom_ok, 1);
        check("post_rst_data", rom_data, 16'h5678);

        // ack outside REQ is ignored
        sdram_ack = 1'b1;
        step(); sdram_ack = 1'b0; #1;
        check("stray_ack_req", sdram_req, 0);
        check("stray_ack_ok", rom_ok, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
